// File: rtl/morse_tx_encoder.sv
// morse_tx_encoder: accepts ASCII characters over a valid/ready handshake and
// keys them out as timed Morse marks and spaces (unit time U = dot length).
// Optional feature: define MORSE_TX_DIGITS_EN to encode '0'-'9'; otherwise
// digits are reported as unsupported.
//
// Handshake: a character is accepted on a rising clk edge where
// char_valid && char_ready; char_ready is high only in IDLE, and the producer
// must hold char_data stable while char_valid is high and not yet accepted.
module morse_tx_encoder #(
    parameter int unsigned MIN_UNIT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] unit_cycles,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    input  logic        abort,
    output logic        tone_on,
    output logic        dot_pulse,
    output logic        dash_pulse,
    output logic        char_done,
    output logic        unsupported,
    output logic        busy,
    output logic [2:0]  o_dbg_state
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_MARK     = 3'd1;
    localparam logic [2:0] S_ELEM_GAP = 3'd2;
    localparam logic [2:0] S_CHAR_GAP = 3'd3;
    localparam logic [2:0] S_WORD_GAP = 3'd4;
    localparam logic [2:0] S_UNSUP    = 3'd5;

    // A zero floor would make durations of zero cycles; never go below one.
    localparam logic [31:0] W_FLOOR = (MIN_UNIT < 1) ? 32'd1 : 32'(MIN_UNIT);

    // Returns {length[2:0], pattern[4:0]}; pattern is left-aligned (first
    // element in bit 4), 1 = dash. Length 0 means no code for this char.
    function automatic logic [7:0] lookup(input logic [7:0] c);
        logic [7:0] u;
        u = (c >= 8'h61 && c <= 8'h7A) ? (c - 8'h20) : c;
        case (u)
            8'h41: lookup = {3'd2, 5'b01000}; // A .-
            8'h42: lookup = {3'd4, 5'b10000}; // B -...
            8'h43: lookup = {3'd4, 5'b10100}; // C -.-.
            8'h44: lookup = {3'd3, 5'b10000}; // D -..
            8'h45: lookup = {3'd1, 5'b00000}; // E .
            8'h46: lookup = {3'd4, 5'b00100}; // F ..-.
            8'h47: lookup = {3'd3, 5'b11000}; // G --.
            8'h48: lookup = {3'd4, 5'b00000}; // H ....
            8'h49: lookup = {3'd2, 5'b00000}; // I ..
            8'h4A: lookup = {3'd4, 5'b01110}; // J .---
            8'h4B: lookup = {3'd3, 5'b10100}; // K -.-
            8'h4C: lookup = {3'd4, 5'b01000}; // L .-..
            8'h4D: lookup = {3'd2, 5'b11000}; // M --
            8'h4E: lookup = {3'd2, 5'b10000}; // N -.
            8'h4F: lookup = {3'd3, 5'b11100}; // O ---
            8'h50: lookup = {3'd4, 5'b01100}; // P .--.
            8'h51: lookup = {3'd4, 5'b11010}; // Q --.-
            8'h52: lookup = {3'd3, 5'b01000}; // R .-.
            8'h53: lookup = {3'd3, 5'b00000}; // S ...
            8'h54: lookup = {3'd1, 5'b10000}; // T -
            8'h55: lookup = {3'd3, 5'b00100}; // U ..-
            8'h56: lookup = {3'd4, 5'b00010}; // V ...-
            8'h57: lookup = {3'd3, 5'b01100}; // W .--
            8'h58: lookup = {3'd4, 5'b10010}; // X -..-
            8'h59: lookup = {3'd4, 5'b10110}; // Y -.--
            8'h5A: lookup = {3'd4, 5'b11000}; // Z --..
`ifdef MORSE_TX_DIGITS_EN
            8'h30: lookup = {3'd5, 5'b11111}; // 0 -----
            8'h31: lookup = {3'd5, 5'b01111}; // 1 .----
            8'h32: lookup = {3'd5, 5'b00111}; // 2 ..---
            8'h33: lookup = {3'd5, 5'b00011}; // 3 ...--
            8'h34: lookup = {3'd5, 5'b00001}; // 4 ....-
            8'h35: lookup = {3'd5, 5'b00000}; // 5 .....
            8'h36: lookup = {3'd5, 5'b10000}; // 6 -....
            8'h37: lookup = {3'd5, 5'b11000}; // 7 --...
            8'h38: lookup = {3'd5, 5'b11100}; // 8 ---..
            8'h39: lookup = {3'd5, 5'b11110}; // 9 ----.
`endif
            default: lookup = 8'h00;
        endcase
    endfunction

    logic [2:0]  r_state;
    logic [33:0] r_cnt;     // cycles elapsed in the current state
    logic [31:0] r_unit;    // U latched at accept
    logic [4:0]  r_pat;     // remaining elements, current one in bit 4
    logic [2:0]  r_left;    // elements remaining including the current one

    logic        w_accept;
    logic [7:0]  w_code;
    logic [31:0] w_u_in;
    logic [33:0] w_u1;
    logic [33:0] w_u3;
    logic [33:0] w_u4;
    logic [33:0] w_dur;
    logic        w_last;

    assign w_accept = char_valid && char_ready;
    assign w_code   = lookup(char_data);
    assign w_u_in   = (unit_cycles < W_FLOOR) ? W_FLOOR : unit_cycles;
    assign w_u1     = {2'b00, r_unit};
    assign w_u3     = (w_u1 << 1) + w_u1;
    assign w_u4     = w_u1 << 2;

    // Length of the current state in cycles, from the latched unit.
    always_comb begin
        w_dur = 34'd1;
        case (r_state)
            S_MARK:     w_dur = r_pat[4] ? w_u3 : w_u1;
            S_ELEM_GAP: w_dur = w_u1;
            S_CHAR_GAP: w_dur = w_u3;
            S_WORD_GAP: w_dur = w_u4;
            default:    w_dur = 34'd1;
        endcase
    end

    assign w_last = (r_cnt == (w_dur - 34'd1));

    // Outputs decode the registered state so reset clears them immediately.
    assign char_ready  = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign tone_on     = (r_state == S_MARK);
    assign dot_pulse   = (r_state == S_MARK) && (r_cnt == 34'd0) && !r_pat[4];
    assign dash_pulse  = (r_state == S_MARK) && (r_cnt == 34'd0) &&  r_pat[4];
    assign char_done   = ((r_state == S_CHAR_GAP) || (r_state == S_WORD_GAP)) && w_last;
    assign unsupported = (r_state == S_UNSUP);
    assign o_dbg_state = r_state;

    // Sequencer: accept/lookup in IDLE, then step through marks and gaps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 34'd0;
            r_unit  <= 32'd1;
            r_pat   <= 5'd0;
            r_left  <= 3'd0;
        end else if (r_state == S_IDLE) begin
            r_cnt <= 34'd0;
            if (w_accept) begin
                r_unit <= w_u_in;
                r_pat  <= w_code[4:0];
                r_left <= w_code[7:5];
                if (char_data == 8'h20)
                    r_state <= S_WORD_GAP;
                else if (w_code[7:5] != 3'd0)
                    r_state <= S_MARK;
                else
                    r_state <= S_UNSUP;
            end
        end else if (abort) begin
            r_state <= S_IDLE;
            r_cnt   <= 34'd0;
        end else if (r_state == S_UNSUP) begin
            r_state <= S_IDLE;
        end else if (w_last) begin
            r_cnt <= 34'd0;
            case (r_state)
                S_MARK: begin
                    r_pat   <= {r_pat[3:0], 1'b0};
                    r_left  <= r_left - 3'd1;
                    r_state <= (r_left == 3'd1) ? S_CHAR_GAP : S_ELEM_GAP;
                end
                S_ELEM_GAP: r_state <= S_MARK;
                default:    r_state <= S_IDLE;
            endcase
        end else begin
            r_cnt <= r_cnt + 34'd1;
        end
    end

endmodule

// File: tb/tb_morse_tx_encoder.sv
// tb_morse_tx_encoder: drives characters into morse_tx_encoder and compares
// every output cycle against a trace built from a Morse string table.
module tb_morse_tx_encoder;

  logic        clk;
  logic        rst_n;
  logic [31:0] unit_cycles;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready;
  logic        abort;
  logic        tone_on;
  logic        dot_pulse;
  logic        dash_pulse;
  logic        char_done;
  logic        unsupported;
  logic        busy;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // {ready, busy, tone, dot, dash, done, unsupported}
  logic [6:0] exp_q[$];
  localparam logic [6:0] IDLE_V = 7'b1000000;

  string letters[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                         "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                         "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                         "-.--", "--.."};
  string digits[10] = '{"-----", ".----", "..---", "...--", "....-",
                        ".....", "-....", "--...", "---..", "----."};

  morse_tx_encoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .unit_cycles (unit_cycles),
    .char_valid  (char_valid),
    .char_data   (char_data),
    .char_ready  (char_ready),
    .abort       (abort),
    .tone_on     (tone_on),
    .dot_pulse   (dot_pulse),
    .dash_pulse  (dash_pulse),
    .char_done   (char_done),
    .unsupported (unsupported),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // ---- clock ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] sample();
    return {char_ready, busy, tone_on, dot_pulse, dash_pulse, char_done, unsupported};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---- model: expected per-cycle trace after accept ----
  task automatic build_trace(input logic [7:0] ch, input int u);
    logic [7:0] c;
    string code;
    bit ok;
    exp_q.delete();
    c = ch;
    if (c >= "a" && c <= "z") c = c - 8'd32;
    ok = 1'b0;
    code = "";
    if (c >= "A" && c <= "Z") begin
      code = letters[c - 8'h41];
      ok = 1'b1;
    end
`ifdef MORSE_TX_DIGITS_EN
    if (c >= "0" && c <= "9") begin
      code = digits[c - 8'h30];
      ok = 1'b1;
    end
`endif
    if (c == 8'h20) begin
      for (int j = 0; j < 4 * u; j++)
        exp_q.push_back({1'b0, 1'b1, 3'b000, (j == 4 * u - 1), 1'b0});
    end else if (!ok) begin
      exp_q.push_back(7'b0100001);
    end else begin
      for (int i = 0; i < code.len(); i++) begin
        bit is_dash;
        int len;
        is_dash = (code[i] == "-");
        len = is_dash ? 3 * u : u;
        for (int j = 0; j < len; j++)
          exp_q.push_back({1'b0, 1'b1, 1'b1, (j == 0) && !is_dash, (j == 0) && is_dash, 2'b00});
        if (i != code.len() - 1)
          for (int j = 0; j < u; j++) exp_q.push_back(7'b0100000);
      end
      for (int j = 0; j < 3 * u; j++)
        exp_q.push_back({1'b0, 1'b1, 3'b000, (j == 3 * u - 1), 1'b0});
    end
    exp_q.push_back(IDLE_V);
  endtask

  // ---- driver: send one character and score every following cycle ----
  task automatic send(input logic [7:0] ch, input logic [31:0] unit,
                      input int abort_at, input bit abort_with_accept);
    int u;
    int k;
    string tag;
    logic [6:0] exp;
    u = (unit == 0) ? 1 : int'(unit);
    tag = $sformatf("chr%02h_u%0d", ch, unit);
    check_eq({tag, "_ready_pre"}, char_ready, 1'b1);
    build_trace(ch, u);
    char_valid  = 1'b1;
    char_data   = ch;
    unit_cycles = unit;
    abort       = abort_with_accept;
    @(posedge clk);
    #1;
    char_valid  = 1'b0;
    abort       = 1'b0;
    unit_cycles = $urandom_range(1, 9);  // must not affect this character
    char_data   = 8'($urandom_range(0, 255));
    k = 1;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check_eq($sformatf("%s_c%0d", tag, k), sample(), exp);
      if (k == abort_at) begin
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check_eq($sformatf("%s_abort_c%0d", tag, k + 1), sample(), IDLE_V);
        @(posedge clk);
        #1;
        check_eq($sformatf("%s_abort_c%0d", tag, k + 2), sample(), IDLE_V);
        exp_q.delete();
      end else if (exp_q.size() > 0) begin
        @(posedge clk);
        #1;
      end
      k++;
    end
  endtask

  // ---- main sequence ----
  initial begin
    string pool;
    rst_n       = 1'b0;
    unit_cycles = 32'd4;
    char_valid  = 1'b0;
    char_data   = 8'h00;
    abort       = 1'b0;
    #12;
    check_eq("reset_outputs", sample(), IDLE_V);
    check_eq("reset_state", dbg_state, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send("E", 32'd4, 0, 1'b0);
    send("a", 32'd4, 0, 1'b0);
    send("A", 32'd4, 0, 1'b0);
    send(" ", 32'd2, 0, 1'b0);
    send("#", 32'd3, 0, 1'b0);
    send("T", 32'd4, 5, 1'b0);
    send("5", 32'd1, 0, 1'b0);
    send("0", 32'd2, 0, 1'b0);
    send("E", 32'd0, 0, 1'b0);   // zero unit clamps to one cycle
    send("N", 32'd2, 0, 1'b1);   // abort alongside accept: accept wins
    send("Q", 32'd1, 0, 1'b0);

    // abort while idle is ignored
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check_eq("idle_abort", sample(), IDLE_V);
    check_eq("idle_abort_state", dbg_state, 3'd0);

    // randomized characters and unit lengths
    pool = "ETAIMNOSQZ kx#9?";
    for (int n = 0; n < 16; n++) begin
      logic [7:0] ch;
      ch = pool[$urandom_range(0, pool.len() - 1)];
      send(ch, 32'($urandom_range(1, 4)), 0, 1'b0);
    end

    // reset asserted mid-character clears outputs without a clock edge
    char_valid  = 1'b1;
    char_data   = "O";
    unit_cycles = 32'd3;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("mid_char_tone", tone_on, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_reset_outputs", sample(), IDLE_V);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send("S", 32'd1, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
